sram_access_ctrl: RTL and testbench
===================================

# sram_access_ctrl

Single-port SRAM access sequencer for the SRAM controller. Accepts one 32-bit word request at a time from the bus-side front end, drives the external asynchronous SRAM's chip/write/output strobes with a programmable number of wait states, and returns read data or a write acknowledge. The block can optionally byte-reverse data and byte enables between bus order and SRAM order.

## Interface
Parameters:
- ADDR_W, 18: request byte-address width; SRAM word address is ADDR_W-2 bits.
- WAIT_STATES, 1: extra ACCESS cycles beyond the minimum of one; legal range 0..15.

Ports:
- Clocking: one clock; reset is asynchronous and active-low. Ports are named CLK and nRST.
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data, bus byte order.
- req_byte_en  in  4  active-high byte enables, bus order.
- rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
- rsp_rdata  out  32  read data, bus order; held until the next read completes.
- sram_ce_n  out  1  chip enable, active-low.
- sram_we_n  out  1  write strobe, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_be_n  out  4  byte enables, active-low.
- sram_addr  out  ADDR_W-2  word address.
- sram_wdata  out  32  write data.
- sram_wdata_oe  out  1  data-bus drive enable.
- sram_rdata  in  32  data returned from the SRAM.

## Operation
- State machine: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - req_ready = 1; all other outputs are registered.
  - A request is accepted when req_valid and req_ready are both high.
  - On acceptance, latch addr (word address req_addr[ADDR_W-1:2]), wdata, be_n = ~byte_en, and wen.
- SETUP (1 cycle):
  - sram_ce_n = 0.
  - Address and be_n are driven; we_n and oe_n stay high.
  - For a write, sram_wdata_oe = 1.
- ACCESS (WAIT_STATES+1 cycles):
  - Write: sram_we_n = 0.
  - Read: sram_oe_n = 0.
  - On the final ACCESS cycle of a read, register sram_rdata into rsp_rdata.
- DONE (1 cycle):
  - we_n and oe_n go high; ce_n stays low; wdata_oe stays high for a write (hold time).
  - rsp_valid = 1.
  - Next state is IDLE.
- A write with req_byte_en = 0 still walks the full sequence with sram_be_n = 4'hF. sram_we_n is still pulsed, and rsp_valid fires at the normal cycle.
- req_ready = 0 in every non-IDLE state. Requests presented then are not accepted and must be held by the source.
- rsp_rdata is unchanged by writes.

## Timing
- Request accepted at edge 0. The state sequence is:
  - SETUP: cycle 1.
  - ACCESS: cycles 2..2+WAIT_STATES.
  - DONE: cycle 3+WAIT_STATES, with rsp_valid high.
  - IDLE: cycle 4+WAIT_STATES, where req_ready is high again.
- Occupancy is WAIT_STATES+4 cycles per request. There is no back-to-back overlap.
- Reset values: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, sram_ce_n/we_n/oe_n = 1, sram_be_n = 4'hF, sram_addr = 0, sram_wdata = 0, sram_wdata_oe = 0.
- Reset asserted mid-operation: strobes deassert immediately (asynchronously). No rsp_valid is produced, and the in-flight request is dropped.
- The wait counter is 4 bits. It loads WAIT_STATES on entry to ACCESS and leaves ACCESS when it reaches 0.

## Configuration
- SRAM_ENDIAN_SWAP_EN
  - Defined:
    - sram_wdata bytes are reversed relative to req_wdata (byte0 <-> byte3, byte1 <-> byte2).
    - sram_be_n bits are reversed correspondingly.
    - rsp_rdata is the byte-reverse of the sampled sram_rdata.
  - Undefined: data and enables pass straight through; the swap logic is not present.
  - Cycle timing is identical either way.

## Structure
- Package sram_ctrl_pkg:
  - typedef enum for the states (IDLE, SETUP, ACCESS, DONE).
  - the width-4 wait-count typedef.
  - the default WAIT_STATES constant.
- One sub-module: sram_wait_timer (load, decrement, zero flag). The FSM instantiates it once.
- The byte swap is a generate-loop inside this block, guarded by the macro.

## Test plan
- Write with WAIT_STATES=1: addr 0x00010, data 0x11223344, byte_en 4'hF.
  - sram_addr = 0x4; we_n is low for 2 cycles.
  - rsp_valid at cycle 4; req_ready high at cycle 5.
- Read of the same word, with the model returning 0x11223344 (macro undefined).
  - oe_n is low for 2 cycles; rsp_rdata = 0x11223344 with rsp_valid at cycle 4.
- Same write with SRAM_ENDIAN_SWAP_EN defined and byte_en 4'b0001.
  - sram_wdata = 0x44332211; sram_be_n = 4'b0111.
- WAIT_STATES=0 and WAIT_STATES=15.
  - ACCESS lasts 1 and 16 cycles respectively; rsp_valid at cycles 3 and 18.
- req_valid held high during a busy read.
  - The second request is accepted only when req_ready returns.
  - Exactly one rsp_valid pulse per request.
- nRST asserted during ACCESS of a write.
  - Outputs take reset values immediately; no rsp_valid.
  - The next request after reset release completes normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and constants for the SRAM access sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_ctrl_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Wait-state counter value (0..15 extra ACCESS cycles)
  typedef logic [3:0] wait_cnt_t;

  localparam int WAIT_STATES_DEFAULT = 1;

endpackage : sram_ctrl_pkg

`default_nettype wire

// File: rtl/sram_wait_timer.sv
// ---------------------------------------------------------------------------
// sram_wait_timer
// Loadable down-counter that times the ACCESS phase of an SRAM cycle.
// Stops at zero and reports zero through zero_o.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_wait_timer
  import sram_ctrl_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      load_i,
  input  wait_cnt_t load_val_i,
  input  logic      dec_i,
  output logic      zero_o
);

  wait_cnt_t cnt_q;
  wait_cnt_t cnt_d;

  // Load has priority over decrement; the count never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : sram_wait_timer

`default_nettype wire

// File: rtl/sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// sram_access_ctrl
// Single-port asynchronous SRAM access sequencer: one 32-bit word request at
// a time, IDLE -> SETUP -> ACCESS (WAIT_STATES+1 cycles) -> DONE -> IDLE.
// Optional feature macro: SRAM_ENDIAN_SWAP_EN (byte-reverse data and byte
// enables between bus order and SRAM order).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_byte_en,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [3:0]        sram_be_n,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_wdata_oe,
  input  logic [31:0]       sram_rdata
);

  localparam wait_cnt_t WAIT_LOAD = wait_cnt_t'(WAIT_STATES);

  state_e state_q, state_d;

  logic              wen_q, wen_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_n_q, be_n_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              wdata_oe_q, wdata_oe_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic              accept;
  logic              timer_zero;
  logic [31:0]       wdata_sram;
  logic [3:0]        be_n_sram;
  logic [31:0]       rdata_bus;

  // Byte-lane address bits carry no meaning for a word-wide SRAM
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // Lane mapping between bus byte order and SRAM byte order
`ifdef SRAM_ENDIAN_SWAP_EN
  for (genvar b = 0; b < 4; b++) begin : g_swap
    assign wdata_sram[8*b +: 8] = req_wdata[8*(3-b) +: 8];
    assign be_n_sram[b]         = ~req_byte_en[3-b];
    assign rdata_bus[8*b +: 8]  = sram_rdata[8*(3-b) +: 8];
  end
`else
  assign wdata_sram = req_wdata;
  assign be_n_sram  = ~req_byte_en;
  assign rdata_bus  = sram_rdata;
`endif

  // Loaded during SETUP so it holds WAIT_STATES on the first ACCESS cycle
  sram_wait_timer u_wait_timer (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .load_i     (state_q == SETUP),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == ACCESS),
    .zero_o     (timer_zero)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (timer_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, read-data capture and strobes decoded from the next state
  always_comb begin
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_n_d  = be_n_q;
    rdata_d = rdata_q;
    if (accept) begin
      wen_d   = req_wen;
      addr_d  = req_addr[ADDR_W-1:2];
      wdata_d = wdata_sram;
      be_n_d  = be_n_sram;
    end
    if ((state_q == ACCESS) && timer_zero && !wen_q) begin
      rdata_d = rdata_bus;
    end
    ce_n_d      = (state_d == IDLE);
    we_n_d      = !((state_d == ACCESS) && wen_d);
    oe_n_d      = !((state_d == ACCESS) && !wen_d);
    wdata_oe_d  = wen_d && (state_d != IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  // Output and datapath registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_n_q      <= 4'hF;
      rdata_q     <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      wdata_oe_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_n_q      <= be_n_d;
      rdata_q     <= rdata_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      wdata_oe_q  <= wdata_oe_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_we_n     = we_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_be_n     = be_n_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_wdata_oe = wdata_oe_q;

endmodule : sram_access_ctrl

`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_access_ctrl
// Self-checking bench for sram_access_ctrl: vector table on a WAIT_STATES=1
// instance with an SRAM model and a response scoreboard, plus WAIT_STATES=0
// and WAIT_STATES=15 instances for latency, reset-abort and held-request
// sequences. Honors SRAM_ENDIAN_SWAP_EN when defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_sram_access_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        req_wen = 1'b0;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_byte_en = '0;
  logic        req_valid = 1'b0;
  logic        rv_w0 = 1'b0;
  logic        rv_w15 = 1'b0;

  // main instance (WAIT_STATES=1)
  logic        req_ready, rsp_valid, sram_ce_n, sram_we_n, sram_oe_n, sram_wdata_oe;
  logic [31:0] rsp_rdata, sram_wdata, sram_rdata;
  logic [3:0]  sram_be_n;
  logic [15:0] sram_addr;
  // WAIT_STATES=0 instance
  logic        w0_ready, w0_rsp, w0_ce_n, w0_we_n, w0_oe_n, w0_wdoe;
  logic [31:0] w0_rdata, w0_wdata;
  logic [3:0]  w0_be_n;
  logic [15:0] w0_addr;
  // WAIT_STATES=15 instance
  logic        w15_ready, w15_rsp, w15_ce_n, w15_we_n, w15_oe_n, w15_wdoe;
  logic [31:0] w15_rdata, w15_wdata;
  logic [3:0]  w15_be_n;
  logic [15:0] w15_addr;

  int total = 0;
  int bad = 0;
  int rsp_cnt = 0;

  always #5 CLK = ~CLK;

  sram_access_ctrl #(.ADDR_W(18), .WAIT_STATES(1)) dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_be_n(sram_be_n), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wdata_oe(sram_wdata_oe), .sram_rdata(sram_rdata)
  );

  sram_access_ctrl #(.ADDR_W(18), .WAIT_STATES(0)) dut_w0 (
    .CLK(CLK), .nRST(nRST), .req_valid(rv_w0), .req_ready(w0_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en), .rsp_valid(w0_rsp), .rsp_rdata(w0_rdata),
    .sram_ce_n(w0_ce_n), .sram_we_n(w0_we_n), .sram_oe_n(w0_oe_n),
    .sram_be_n(w0_be_n), .sram_addr(w0_addr), .sram_wdata(w0_wdata),
    .sram_wdata_oe(w0_wdoe), .sram_rdata(32'h0)
  );

  sram_access_ctrl #(.ADDR_W(18), .WAIT_STATES(15)) dut_w15 (
    .CLK(CLK), .nRST(nRST), .req_valid(rv_w15), .req_ready(w15_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en), .rsp_valid(w15_rsp), .rsp_rdata(w15_rdata),
    .sram_ce_n(w15_ce_n), .sram_we_n(w15_we_n), .sram_oe_n(w15_oe_n),
    .sram_be_n(w15_be_n), .sram_addr(w15_addr), .sram_wdata(w15_wdata),
    .sram_wdata_oe(w15_wdoe), .sram_rdata(32'h0)
  );

  function automatic logic [31:0] sw32(input logic [31:0] d);
`ifdef SRAM_ENDIAN_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [3:0] sw4(input logic [3:0] b);
`ifdef SRAM_ENDIAN_SWAP_EN
    return {b[0], b[1], b[2], b[3]};
`else
    return b;
`endif
  endfunction

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | (i * 32'h0000_0111);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // SRAM model, stored in SRAM byte order
  logic [31:0] sram_mem [16];
  logic        mem_init = 1'b0;
  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[3:0]] : 32'h0BAD_0BAD;

  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) sram_mem[i] <= pat(i);
      mem_init <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr[3:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Scoreboard: accepted requests queued, retired on rsp_valid
  typedef struct {
    logic        wen;
    logic [3:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;
  req_t sb_q[$];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) sb_q.delete();
    else if (req_valid && req_ready)
      sb_q.push_back('{wen: req_wen, idx: req_addr[5:2], wdata: req_wdata, be: req_byte_en});
  end

  // Bus-order reference memory and last read value
  logic [31:0] shadow [16];
  logic        sh_init = 1'b0;
  logic [31:0] last_rd = '0;

  always @(negedge CLK) begin
    req_t r;
    if (!sh_init) begin
      for (int i = 0; i < 16; i++) shadow[i] = sw32(pat(i));
      sh_init = 1'b1;
    end
    if (!nRST) begin
      last_rd = '0;
    end else if (rsp_valid) begin
      rsp_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        r = sb_q.pop_front();
        if (r.wen) begin
          for (int b = 0; b < 4; b++)
            if (r.be[b]) shadow[r.idx][8*b +: 8] = r.wdata[8*b +: 8];
          chk("rdata_held_on_write", rsp_rdata, last_rd);
        end else begin
          chk("rsp_rdata", rsp_rdata, shadow[r.idx]);
          last_rd = shadow[r.idx];
        end
      end
    end
  end

  typedef struct {
    logic        wen;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [15:0] exp_addr;
  } vec_t;

  // One request on the main instance with cycle-by-cycle strobe checks
  task automatic run_txn(input vec_t v);
    int we_low, oe_low, rsp_cyc, rdy_cyc;
    @(negedge CLK);
    req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata; req_byte_en = v.be;
    req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    we_low = 0; oe_low = 0; rsp_cyc = -1; rdy_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        chk("setup_ce_n", {31'd0, sram_ce_n}, 32'd0);
        chk("setup_we_oe", {30'd0, sram_we_n, sram_oe_n}, 32'd3);
        chk("setup_addr", {16'd0, sram_addr}, {16'd0, v.exp_addr});
        chk("setup_be_n", {28'd0, sram_be_n}, {28'd0, sw4(~v.be)});
        chk("setup_wdata_oe", {31'd0, sram_wdata_oe}, {31'd0, v.wen});
        if (v.wen) chk("setup_wdata", sram_wdata, sw32(v.wdata));
      end
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (rsp_valid && rsp_cyc < 0) begin
        rsp_cyc = k;
        chk("done_ce_n", {31'd0, sram_ce_n}, 32'd0);
        chk("done_wdata_oe", {31'd0, sram_wdata_oe}, {31'd0, v.wen});
      end
      if (req_ready) begin
        rdy_cyc = k;
        break;
      end
    end
    chk("we_low_cycles", we_low, v.wen ? 32'd2 : 32'd0);
    chk("oe_low_cycles", oe_low, v.wen ? 32'd0 : 32'd2);
    chk("rsp_cycle", rsp_cyc, 32'd4);
    chk("ready_cycle", rdy_cyc, 32'd5);
  endtask

  // Latency of the WAIT_STATES=0 / 15 instances
  task automatic measure(input int which, input int exp_acc, input int exp_rsp);
    int we_low, rsp_cyc, rdy_cyc;
    logic we_n_s, rsp_s, rdy_s;
    @(negedge CLK);
    req_wen = 1'b1; req_addr = 18'h00100; req_wdata = 32'h5555_AAAA; req_byte_en = 4'hF;
    if (which == 0) rv_w0 = 1'b1; else rv_w15 = 1'b1;
    @(posedge CLK);
    #1 rv_w0 = 1'b0; rv_w15 = 1'b0;
    we_low = 0; rsp_cyc = -1; rdy_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      we_n_s = (which == 0) ? w0_we_n : w15_we_n;
      rsp_s  = (which == 0) ? w0_rsp : w15_rsp;
      rdy_s  = (which == 0) ? w0_ready : w15_ready;
      if (!we_n_s) we_low++;
      if (rsp_s && rsp_cyc < 0) rsp_cyc = k;
      if (rdy_s) begin
        rdy_cyc = k;
        break;
      end
    end
    chk($sformatf("ws%0d_access_len", which), we_low, exp_acc);
    chk($sformatf("ws%0d_rsp_cycle", which), rsp_cyc, exp_rsp);
    chk($sformatf("ws%0d_ready_cycle", which), rdy_cyc, exp_rsp + 1);
  endtask

  task automatic drain();
    for (int c = 0; c < 30; c++) begin
      if (sb_q.size() == 0 && req_ready) break;
      @(negedge CLK);
    end
    chk("drain_sb_empty", sb_q.size(), 32'd0);
  endtask

  vec_t vecs [11];

  initial begin
    int acc_cyc [2];
    int n, rsp_before;
    vec_t v;

    vecs[0]  = '{1'b1, 18'h00010, 32'h1122_3344, 4'hF,    16'h0004};
    vecs[1]  = '{1'b0, 18'h00010, 32'h0,         4'hF,    16'h0004};
    vecs[2]  = '{1'b1, 18'h00013, 32'hAABB_CCDD, 4'b0001, 16'h0004};
    vecs[3]  = '{1'b0, 18'h00010, 32'h0,         4'hF,    16'h0004};
    vecs[4]  = '{1'b1, 18'h3FFFC, 32'hCAFE_F00D, 4'b0110, 16'hFFFF};
    vecs[5]  = '{1'b0, 18'h3FFFC, 32'h0,         4'hF,    16'hFFFF};
    vecs[6]  = '{1'b1, 18'h00020, 32'h0102_0304, 4'b0000, 16'h0008};
    vecs[7]  = '{1'b0, 18'h00020, 32'h0,         4'hF,    16'h0008};
    vecs[8]  = '{1'b0, 18'h00000, 32'h0,         4'hF,    16'h0000};
    vecs[9]  = '{1'b1, 18'h00010, 32'h1122_3344, 4'b0001, 16'h0004};
    vecs[10] = '{1'b0, 18'h00010, 32'h0,         4'hF,    16'h0004};

    // reset values
    repeat (3) @(negedge CLK);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_strobes", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, 32'd7);
    chk("rst_be_n", {28'd0, sram_be_n}, 32'hF);
    chk("rst_addr", {16'd0, sram_addr}, 32'd0);
    chk("rst_wdata", sram_wdata, 32'd0);
    chk("rst_wdata_oe", {31'd0, sram_wdata_oe}, 32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);
    drain();

    measure(0, 1, 3);
    measure(15, 16, 18);

    // reset asserted during ACCESS of a write
    rsp_before = rsp_cnt;
    @(negedge CLK);
    req_wen = 1'b1; req_addr = 18'h00024; req_wdata = 32'hDEAD_BEEF; req_byte_en = 4'hF;
    req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
    nRST = 1'b0;
    #1;
    chk("midrst_strobes", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, 32'd7);
    chk("midrst_wdata_oe", {31'd0, sram_wdata_oe}, 32'd0);
    chk("midrst_be_n", {28'd0, sram_be_n}, 32'hF);
    chk("midrst_addr", {16'd0, sram_addr}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("midrst_no_rsp", rsp_cnt - rsp_before, 32'd0);
    v = '{1'b1, 18'h00028, 32'h7788_99AA, 4'hF, 16'h000A};
    run_txn(v);
    v = '{1'b0, 18'h00024, 32'h0, 4'hF, 16'h0009};
    run_txn(v);
    v = '{1'b0, 18'h00028, 32'h0, 4'hF, 16'h000A};
    run_txn(v);
    drain();

    // request held valid while the block is busy
    rsp_before = rsp_cnt;
    n = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1;
    @(negedge CLK);
    req_wen = 1'b0; req_addr = 18'h00010; req_byte_en = 4'hF;
    req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge CLK);
      if (req_ready) begin
        acc_cyc[n] = c;
        n++;
        if (n == 2) begin
          @(posedge CLK);
          #1 req_valid = 1'b0;
          break;
        end
      end
    end
    req_valid = 1'b0;
    chk("held_accepts", n, 32'd2);
    chk("held_accept_spacing", acc_cyc[1] - acc_cyc[0], 32'd5);
    repeat (8) @(negedge CLK);
    drain();
    chk("held_rsp_pulses", rsp_cnt - rsp_before, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_sram_access_ctrl

`default_nettype wire
